// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Shared types and helpers for the memory controller channels.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Per-channel handshake state
  typedef enum logic [2:0] {
    CH_IDLE          = 3'd0,
    CH_READ_WAITING  = 3'd1,
    CH_WRITE_WAITING = 3'd2,
    CH_READ_RELAY    = 3'd3,
    CH_WRITE_RELAY   = 3'd4
  } ch_state_e;

  // Grant opcode: which side of a lane's request a channel picked up
  localparam logic c_op_read  = 1'b1;
  localparam logic c_op_write = 1'b0;

  // Lane index (base + offset) wrapped into [0, n)
  function automatic int wrap_lane(input int base, input int offset, input int n);
    int s;
    s = base + offset;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_channel.sv
`default_nettype none
// ============================================================================
// Module   : mem_channel
// Purpose  : One external memory channel: handshake FSM, round-robin pointer
//            and registered mem-side request outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_channel
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int LANE_BITS     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_grant,
  input  logic                     i_grant_op,
  input  logic [LANE_BITS-1:0]     i_grant_lane,
  input  logic [ADDR_BITS-1:0]     i_grant_addr,
  input  logic [DATA_BITS-1:0]     i_grant_data,
  input  logic [NUM_CONSUMERS-1:0] i_lane_read_valid,
  input  logic [NUM_CONSUMERS-1:0] i_lane_write_valid,
  input  logic                     i_mem_read_ready,
  input  logic                     i_mem_write_ready,
  output logic                     o_idle,
  output logic [LANE_BITS-1:0]     o_lane,
  output logic [LANE_BITS-1:0]     o_ptr,
  output logic                     o_read_done,
  output logic                     o_write_done,
  output logic                     o_release,
  output logic                     o_mem_read_valid,
  output logic [ADDR_BITS-1:0]     o_mem_read_address,
  output logic                     o_mem_write_valid,
  output logic [ADDR_BITS-1:0]     o_mem_write_address,
  output logic [DATA_BITS-1:0]     o_mem_write_data
);

  ch_state_e            r_state;
  logic [LANE_BITS-1:0] r_lane;
  logic [LANE_BITS-1:0] r_ptr;

  // Status and completion events seen by the parent in the current cycle
  always_comb begin
    o_idle       = (r_state == CH_IDLE);
    o_lane       = r_lane;
    o_ptr        = r_ptr;
    o_read_done  = (r_state == CH_READ_WAITING)  && i_mem_read_ready;
    o_write_done = (r_state == CH_WRITE_WAITING) && i_mem_write_ready;
    o_release    = ((r_state == CH_READ_RELAY)  && !i_lane_read_valid[r_lane]) ||
                   ((r_state == CH_WRITE_RELAY) && !i_lane_write_valid[r_lane]);
  end

  // Channel FSM with registered memory-side request outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= CH_IDLE;
      r_lane              <= '0;
      r_ptr               <= '0;
      o_mem_read_valid    <= 1'b0;
      o_mem_read_address  <= '0;
      o_mem_write_valid   <= 1'b0;
      o_mem_write_address <= '0;
      o_mem_write_data    <= '0;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_grant) begin
            r_lane <= i_grant_lane;
            r_ptr  <= LANE_BITS'(wrap_lane(int'(i_grant_lane), 1, NUM_CONSUMERS));
            if (i_grant_op == c_op_read) begin
              o_mem_read_valid   <= 1'b1;
              o_mem_read_address <= i_grant_addr;
              r_state            <= CH_READ_WAITING;
            end else begin
              o_mem_write_valid   <= 1'b1;
              o_mem_write_address <= i_grant_addr;
              o_mem_write_data    <= i_grant_data;
              r_state             <= CH_WRITE_WAITING;
            end
          end
        end
        CH_READ_WAITING: begin
          if (i_mem_read_ready) begin
            o_mem_read_valid <= 1'b0;
            r_state          <= CH_READ_RELAY;
          end
        end
        CH_WRITE_WAITING: begin
          if (i_mem_write_ready) begin
            o_mem_write_valid <= 1'b0;
            r_state           <= CH_WRITE_RELAY;
          end
        end
        CH_READ_RELAY, CH_WRITE_RELAY: begin
          // Lane stays owned until it drops its request
          if (o_release) r_state <= CH_IDLE;
        end
        default: r_state <= CH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_controller
// Purpose  : Arbitrates per-lane load/store handshakes onto NUM_CHANNELS
//            external memory channels and relays responses back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_controller
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int LANE_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [ADDR_BITS-1:0]     w_rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     w_wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     w_wr_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     r_rd_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] w_wr_valid;
  logic [NUM_CONSUMERS-1:0] r_rd_ready;
  logic [NUM_CONSUMERS-1:0] r_wr_ready;
  logic [NUM_CONSUMERS-1:0] w_owned;
  logic [NUM_CONSUMERS-1:0] w_claimed;
  logic [LANE_BITS-1:0]     w_idx;

  logic [NUM_CHANNELS-1:0]  w_idle, w_read_done, w_write_done, w_release;
  logic [NUM_CHANNELS-1:0]  w_grant, w_grant_op;
  logic [LANE_BITS-1:0]     w_cur_lane   [NUM_CHANNELS];
  logic [LANE_BITS-1:0]     w_ptr        [NUM_CHANNELS];
  logic [LANE_BITS-1:0]     w_grant_lane [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     w_grant_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     w_grant_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     w_mem_rd_data [NUM_CHANNELS];

  // With writes disabled the write requests are simply invisible to the scan
  assign w_wr_valid = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  generate
    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
      assign w_rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = r_rd_data[g];
    end
  endgenerate

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_write_ready = r_wr_ready;

  // Ownership mask plus in-cycle claim scan; lower-index channels claim first
  always_comb begin
    w_idx   = '0;
    w_owned = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!w_idle[c]) w_owned[w_cur_lane[c]] = 1'b1;
    end
    w_claimed = w_owned;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_grant[c]      = 1'b0;
      w_grant_op[c]   = c_op_read;
      w_grant_lane[c] = '0;
      w_grant_addr[c] = '0;
      w_grant_data[c] = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        w_idx = LANE_BITS'(wrap_lane(int'(w_ptr[c]), k, NUM_CONSUMERS));
        if (w_idle[c] && !w_grant[c] && !w_claimed[w_idx] &&
            (consumer_read_valid[w_idx] || w_wr_valid[w_idx])) begin
          w_grant[c]      = 1'b1;
          w_grant_lane[c] = w_idx;
          w_claimed[w_idx] = 1'b1;
          if (consumer_read_valid[w_idx]) begin
            w_grant_op[c]   = c_op_read;
            w_grant_addr[c] = w_rd_addr[w_idx];
          end else begin
            w_grant_op[c]   = c_op_write;
            w_grant_addr[c] = w_wr_addr[w_idx];
            w_grant_data[c] = w_wr_data[w_idx];
          end
        end
      end
    end
  end

  // Per-lane response registers: set on memory completion, cleared on release
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ready <= '0;
      r_wr_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) r_rd_data[i] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_read_done[c]) begin
          r_rd_ready[w_cur_lane[c]] <= 1'b1;
          r_rd_data[w_cur_lane[c]]  <= w_mem_rd_data[c];
        end
        if (w_write_done[c]) r_wr_ready[w_cur_lane[c]] <= 1'b1;
        if (w_release[c]) begin
          r_rd_ready[w_cur_lane[c]] <= 1'b0;
          r_wr_ready[w_cur_lane[c]] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      assign w_mem_rd_data[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];

      mem_channel #(
        .ADDR_BITS     (ADDR_BITS),
        .DATA_BITS     (DATA_BITS),
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .LANE_BITS     (LANE_BITS)
      ) u_chan (
        .clk                 (clk),
        .reset               (reset),
        .i_grant             (w_grant[c]),
        .i_grant_op          (w_grant_op[c]),
        .i_grant_lane        (w_grant_lane[c]),
        .i_grant_addr        (w_grant_addr[c]),
        .i_grant_data        (w_grant_data[c]),
        .i_lane_read_valid   (consumer_read_valid),
        .i_lane_write_valid  (w_wr_valid),
        .i_mem_read_ready    (mem_read_ready[c]),
        .i_mem_write_ready   (mem_write_ready[c]),
        .o_idle              (w_idle[c]),
        .o_lane              (w_cur_lane[c]),
        .o_ptr               (w_ptr[c]),
        .o_read_done         (w_read_done[c]),
        .o_write_done        (w_write_done[c]),
        .o_release           (w_release[c]),
        .o_mem_read_valid    (mem_read_valid[c]),
        .o_mem_read_address  (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
        .o_mem_write_valid   (mem_write_valid[c]),
        .o_mem_write_address (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
        .o_mem_write_data    (mem_write_data[c*DATA_BITS +: DATA_BITS])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_controller
// Purpose  : Scoreboard bench: 2-channel controller under random lane traffic
//            against a reference memory, plus a 1-channel write-disabled copy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT: 4 lanes, 2 channels, writes enabled
  logic [3:0]  c_rv = '0, c_rr, c_wv = '0, c_wr;
  logic [31:0] c_raddr = '0, c_rd, c_waddr = '0, c_wdata = '0;
  logic [1:0]  m_rv, m_rr = '0, m_wv, m_wr = '0;
  logic [15:0] m_raddr, m_rd = '0, m_waddr, m_wdata;

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(2), .WRITE_ENABLE(1)) u_dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_raddr),
    .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
    .consumer_write_valid(c_wv), .consumer_write_address(c_waddr),
    .consumer_write_data(c_wdata), .consumer_write_ready(c_wr),
    .mem_read_valid(m_rv), .mem_read_address(m_raddr),
    .mem_read_ready(m_rr), .mem_read_data(m_rd),
    .mem_write_valid(m_wv), .mem_write_address(m_waddr),
    .mem_write_data(m_wdata), .mem_write_ready(m_wr)
  );

  // Second DUT: 1 channel, writes disabled
  logic [3:0]  n_rv = '0, n_rr, n_wv = '0, n_wr;
  logic [31:0] n_raddr = '0, n_rd, n_waddr = '0, n_wdata = '0;
  logic        n_mrv, n_mrr = 1'b0, n_mwv;
  logic [7:0]  n_mra, n_mrd = '0, n_mwa, n_mwd;

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(1), .WRITE_ENABLE(0)) u_dut_nw (
    .clk(clk), .reset(reset),
    .consumer_read_valid(n_rv), .consumer_read_address(n_raddr),
    .consumer_read_ready(n_rr), .consumer_read_data(n_rd),
    .consumer_write_valid(n_wv), .consumer_write_address(n_waddr),
    .consumer_write_data(n_wdata), .consumer_write_ready(n_wr),
    .mem_read_valid(n_mrv), .mem_read_address(n_mra),
    .mem_read_ready(n_mrr), .mem_read_data(n_mrd),
    .mem_write_valid(n_mwv), .mem_write_address(n_mwa),
    .mem_write_data(n_mwd), .mem_write_ready(1'b0)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name, input int cycles);
    total++;
    $display("FAIL %s: no response within %0d cycles, expected one", name, cycles);
  endtask

  // Reference memory (expected contents) and the external memory model
  logic [7:0] exp_mem [256];
  logic [7:0] mem_arr [256];
  logic       mem_hold = 1'b0;
  int         rdly [2];
  int         wdly [2];

  // Scoreboard: per lane, {is_read, data} in issue order
  logic [8:0] sb [4][$];

  // External memory model for the main DUT: random latency, 4-phase
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_rr[c] = 1'b0; m_wr[c] = 1'b0; rdly[c] = 0; wdly[c] = 0;
      end else begin
        if (m_rr[c] && !m_rv[c]) m_rr[c] = 1'b0;
        else if (m_rv[c] && !m_rr[c] && !mem_hold) begin
          if (rdly[c] == 0) begin
            m_rr[c] = 1'b1;
            m_rd[c*8 +: 8] = mem_arr[m_raddr[c*8 +: 8]];
            rdly[c] = $urandom_range(0, 3);
          end else rdly[c]--;
        end
        if (m_wr[c] && !m_wv[c]) m_wr[c] = 1'b0;
        else if (m_wv[c] && !m_wr[c] && !mem_hold) begin
          if (wdly[c] == 0) begin
            m_wr[c] = 1'b1;
            mem_arr[m_waddr[c*8 +: 8]] = m_wdata[c*8 +: 8];
            wdly[c] = $urandom_range(0, 3);
          end else wdly[c]--;
        end
      end
    end
  end

  // Memory model for the write-disabled DUT: fixed pattern, 1-cycle latency
  always @(negedge clk) begin
    if (reset) n_mrr = 1'b0;
    else if (n_mrr && !n_mrv) n_mrr = 1'b0;
    else if (n_mrv && !n_mrr) begin
      n_mrr = 1'b1;
      n_mrd = n_mra ^ 8'h3C;
    end
  end

  // Monitor: pop the scoreboard whenever a lane's ready rises
  logic [3:0] prev_rr = '0, prev_wr = '0;
  logic [8:0] mon_e;
  logic [1:0] l0, l1;
  logic       nw_bad = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (c_rr[i] && !prev_rr[i]) begin
        if (sb[i].size() == 0) chk("unexpected_read_ready", 32'(i), 32'hFF);
        else begin
          mon_e = sb[i].pop_front();
          chk("read_kind", 32'd1, 32'(mon_e[8]));
          chk("read_data", 32'(c_rd[i*8 +: 8]), 32'(mon_e[7:0]));
        end
      end
      if (c_wr[i] && !prev_wr[i]) begin
        if (sb[i].size() == 0) chk("unexpected_write_ready", 32'(i), 32'hFF);
        else begin
          mon_e = sb[i].pop_front();
          chk("write_kind", 32'd0, 32'(mon_e[8]));
        end
      end
    end
    prev_rr = c_rr;
    prev_wr = c_wr;
    // Lanes own disjoint address quarters, so addr[7:6] names the lane
    if ((m_rv[0] || m_wv[0]) && (m_rv[1] || m_wv[1])) begin
      l0 = m_rv[0] ? m_raddr[7:6]  : m_waddr[7:6];
      l1 = m_rv[1] ? m_raddr[15:14] : m_waddr[15:14];
      chk("no_double_grant", 32'(l0 != l1), 32'd1);
    end
    if (n_mwv || (n_wr != 4'b0)) nw_bad = 1'b1;
  end

  // One lane transaction on the main DUT, full 4-phase handshake
  task automatic lane_txn(input int i, input bit rd, input logic [7:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    if (rd) begin
      sb[i].push_back({1'b1, exp_mem[addr]});
      c_raddr[i*8 +: 8] = addr;
      c_rv[i] = 1'b1;
    end else begin
      exp_mem[addr] = data;
      sb[i].push_back({1'b0, 8'h00});
      c_waddr[i*8 +: 8] = addr;
      c_wdata[i*8 +: 8] = data;
      c_wv[i] = 1'b1;
    end
    n = 0;
    while (!(rd ? c_rr[i] : c_wr[i]) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) fail_bound("lane_response", 300);
    c_rv[i] = 1'b0;
    c_wv[i] = 1'b0;
    n = 0;
    while ((c_rr[i] || c_wr[i]) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail_bound("ready_release", 20);
  endtask

  task automatic lane_run(input int i, input int cnt);
    bit rd;
    logic [1:0] lane;
    logic [7:0] addr;
    lane = i[1:0];
    for (int t = 0; t < cnt; t++) begin
      rd   = 1'($urandom_range(0, 1));
      addr = {lane, 6'($urandom_range(0, 63))};
      lane_txn(i, rd, addr, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  int order [$];
  int cyc;
  int widx;

  initial begin
    for (int a = 0; a < 256; a++) begin
      exp_mem[a] = 8'(a) ^ 8'hA5;
      mem_arr[a] = 8'(a) ^ 8'hA5;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(|{m_rv, m_wv, m_raddr, m_waddr, m_wdata, c_rr, c_wr, c_rd}), 32'd0);
    reset = 1'b0;

    // Four lanes at once on two channels: lanes 0 and 1 granted together
    for (int i = 0; i < 4; i++) begin
      automatic int li = i;
      fork lane_txn(li, 1'b1, {li[1:0], 6'h10}, 8'h00); join_none
    end
    @(negedge clk);
    @(negedge clk);
    chk("burst_both_channels", 32'(m_rv), 32'h3);
    chk("burst_ch0_lane", 32'(m_raddr[7:6]), 32'd0);
    chk("burst_ch1_lane", 32'(m_raddr[15:14]), 32'd1);
    wait fork;

    // Single write from lane 0
    fork
      lane_txn(0, 1'b0, 8'h04, 8'h33);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("write_valid_count", 32'($countones(m_wv)), 32'd1);
        widx = m_wv[1] ? 1 : 0;
        chk("write_address", 32'(m_waddr[widx*8 +: 8]), 32'h04);
        chk("write_data", 32'(m_wdata[widx*8 +: 8]), 32'h33);
      end
    join
    lane_txn(0, 1'b1, 8'h04, 8'h00);

    // Random traffic on all lanes
    for (int i = 0; i < 4; i++) begin
      automatic int li = i;
      fork lane_run(li, 25); join_none
    end
    wait fork;

    // Reset while a read is waiting on memory
    mem_hold = 1'b1;
    @(negedge clk);
    c_raddr[2*8 +: 8] = 8'h90;
    c_rv[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_read_pending", 32'(|m_rv), 32'd1);
    reset = 1'b1;
    c_rv[2] = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 32'(|{m_rv, m_wv, m_raddr, m_waddr, m_wdata, c_rr, c_wr, c_rd}), 32'd0);
    reset = 1'b0;
    mem_hold = 1'b0;
    lane_txn(2, 1'b1, 8'h90, 8'h00);

    // Write-disabled DUT: lane 1 write ignored, reads served in order 0,2,3
    @(negedge clk);
    for (int i = 0; i < 4; i++) n_raddr[i*8 +: 8] = 8'h20 + 8'(i);
    n_waddr[15:8] = 8'h21;
    n_wdata[15:8] = 8'h77;
    n_rv = 4'b1101;
    n_wv = 4'b0010;
    cyc = 0;
    while (order.size() < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (n_rr[i] && n_rv[i]) begin
          order.push_back(i);
          chk("nw_read_data", 32'(n_rd[i*8 +: 8]), 32'((8'h20 + 8'(i)) ^ 8'h3C));
          n_rv[i] = 1'b0;
        end
      end
    end
    if (cyc >= 200) fail_bound("nw_reads", 200);
    repeat (6) @(negedge clk);
    n_wv = 4'b0;
    chk("nw_order_count", 32'(order.size()), 32'd3);
    chk("nw_order_first",  32'((order.size() > 0) ? order[0] : -1), 32'd0);
    chk("nw_order_second", 32'((order.size() > 1) ? order[1] : -1), 32'd2);
    chk("nw_order_third",  32'((order.size() > 2) ? order[2] : -1), 32'd3);
    chk("nw_write_blocked", 32'(nw_bad), 32'd0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("scoreboard_drained", 32'(sb[i].size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
